// File: rtl/pg_port_reset_guard.sv
`default_nettype none
// ============================================================================
// Module   : pg_port_reset_guard
// Purpose  : Per-port reset guard between the port-gasket PF/VF MUX and the
//            AFU port instances. The AFU->FIM (TX) path is store-and-forward,
//            so only whole packets ever reach the MUX. While a port is held in
//            reset, FIM->AFU (RX) beats for that port are sunk and dropped.
//            Every port is independent: RUN -> FLUSH -> HOLD -> RUN.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            port_rst[p]         - per-port reset request (level)
//            tx_s_* / tx_m_*     - TX AXI-S from AFU / toward MUX
//            rx_s_* / rx_m_*     - RX AXI-S from MUX / toward AFU
//            port_quiesced[p]    - port in HOLD with its TX FIFO empty
//            err_oversize[p]     - sticky: a TX packet exceeded FIFO_DEPTH
//            stat_tx_drop/rx_drop- 16-bit saturating drop counters
//            Bus field p occupies slice [p*W +: W].
// Options  : PG_GUARD_STATS_EN   - builds the drop counters; when undefined
//                                  the stat ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pg_port_reset_guard #(
    parameter int NUM_PORTS   = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int FIFO_DEPTH  = 64     // power of 2, >= 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PORTS-1:0]                   port_rst,
    // TX from AFU
    input  logic [NUM_PORTS-1:0]                   tx_s_tvalid,
    output logic [NUM_PORTS-1:0]                   tx_s_tready,
    input  logic [NUM_PORTS-1:0]                   tx_s_tlast,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]       tx_s_tdata,
    input  logic [NUM_PORTS*(TDATA_WIDTH/8)-1:0]   tx_s_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0]       tx_s_tuser,
    // TX toward MUX
    output logic [NUM_PORTS-1:0]                   tx_m_tvalid,
    input  logic [NUM_PORTS-1:0]                   tx_m_tready,
    output logic [NUM_PORTS-1:0]                   tx_m_tlast,
    output logic [NUM_PORTS*TDATA_WIDTH-1:0]       tx_m_tdata,
    output logic [NUM_PORTS*(TDATA_WIDTH/8)-1:0]   tx_m_tkeep,
    output logic [NUM_PORTS*TUSER_WIDTH-1:0]       tx_m_tuser,
    // RX from MUX
    input  logic [NUM_PORTS-1:0]                   rx_s_tvalid,
    output logic [NUM_PORTS-1:0]                   rx_s_tready,
    input  logic [NUM_PORTS-1:0]                   rx_s_tlast,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]       rx_s_tdata,
    input  logic [NUM_PORTS*(TDATA_WIDTH/8)-1:0]   rx_s_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0]       rx_s_tuser,
    // RX toward AFU
    output logic [NUM_PORTS-1:0]                   rx_m_tvalid,
    input  logic [NUM_PORTS-1:0]                   rx_m_tready,
    output logic [NUM_PORTS-1:0]                   rx_m_tlast,
    output logic [NUM_PORTS*TDATA_WIDTH-1:0]       rx_m_tdata,
    output logic [NUM_PORTS*(TDATA_WIDTH/8)-1:0]   rx_m_tkeep,
    output logic [NUM_PORTS*TUSER_WIDTH-1:0]       rx_m_tuser,
    // Status
    output logic [NUM_PORTS-1:0]                   port_quiesced,
    output logic [NUM_PORTS-1:0]                   err_oversize,
    output logic [NUM_PORTS*16-1:0]                stat_tx_drop,
    output logic [NUM_PORTS*16-1:0]                stat_rx_drop
);

    localparam int KW = TDATA_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;                       // extra wrap bit
    localparam int BW = TDATA_WIDTH + KW + TUSER_WIDTH + 1;

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_FLUSH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    // RX payload is a pure pass-through; only valid/ready are gated.
    assign rx_m_tdata = rx_s_tdata;
    assign rx_m_tkeep = rx_s_tkeep;
    assign rx_m_tuser = rx_s_tuser;
    assign rx_m_tlast = rx_s_tlast;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [1:0]    r_state;
        logic [1:0]    w_state_nxt;
        logic [PW-1:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr;
        logic [BW-1:0] r_mem [FIFO_DEPTH];
        logic          r_discard, r_rx_in_pkt, r_err;

        logic          w_run, w_full, w_tx_rdy, w_tx_acc, w_store, w_tx_vld, w_tx_rd;
        logic          w_oversize, w_rst_req, w_rewind;
        logic          w_rx_rdy, w_rx_acc, w_rx_in_pkt_nxt;
        logic [PW-1:0] w_wr_acc, w_cmt_acc;
        logic [BW-1:0] w_wr_beat, w_rd_beat;

        assign w_run    = (r_state == c_ST_RUN);
        assign w_full   = ((r_wr_ptr - r_rd_ptr) == PW'(FIFO_DEPTH));
        // While discarding an oversize tail, beats are taken regardless of fill.
        assign w_tx_rdy = w_run && (r_discard || !w_full);
        assign w_tx_acc = tx_s_tvalid[p] && w_tx_rdy;
        assign w_store  = w_tx_acc && !r_discard;
        assign w_tx_vld = (r_rd_ptr != r_cmt_ptr);
        assign w_tx_rd  = w_tx_vld && tx_m_tready[p];

        // FIFO full with nothing committed: the open packet can never fit.
        assign w_oversize = w_full && (r_rd_ptr == r_cmt_ptr);
        assign w_rst_req  = w_run && port_rst[p];
        assign w_rewind   = w_oversize || w_rst_req;

        // Pointer values after this cycle's write; a tlast accepted in the
        // same cycle as a port_rst rise therefore still commits.
        assign w_wr_acc  = r_wr_ptr + PW'(w_store);
        assign w_cmt_acc = (w_store && tx_s_tlast[p]) ? w_wr_acc : r_cmt_ptr;

        assign w_wr_beat = {tx_s_tlast[p], tx_s_tuser[p*TUSER_WIDTH +: TUSER_WIDTH],
                            tx_s_tkeep[p*KW +: KW], tx_s_tdata[p*TDATA_WIDTH +: TDATA_WIDTH]};
        assign w_rd_beat = r_mem[r_rd_ptr[AW-1:0]];

        assign w_rx_rdy        = w_run ? rx_m_tready[p] : 1'b1;
        assign w_rx_acc        = rx_s_tvalid[p] && w_rx_rdy;
        // Next-cycle view of the upstream packet state, so a beat sunk in HOLD
        // is accounted for before we decide to re-enter RUN.
        assign w_rx_in_pkt_nxt = w_rx_acc ? !rx_s_tlast[p] : r_rx_in_pkt;

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_ST_RUN:   if (port_rst[p])                        w_state_nxt = c_ST_FLUSH;
                c_ST_FLUSH: if (r_rd_ptr == r_cmt_ptr)              w_state_nxt = c_ST_HOLD;
                c_ST_HOLD:  if (!port_rst[p] && !w_rx_in_pkt_nxt)   w_state_nxt = c_ST_RUN;
                default:                                            w_state_nxt = c_ST_HOLD;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state     <= c_ST_HOLD;
                r_wr_ptr    <= '0;
                r_cmt_ptr   <= '0;
                r_rd_ptr    <= '0;
                r_discard   <= 1'b0;
                r_rx_in_pkt <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_rx_in_pkt <= w_rx_in_pkt_nxt;
                r_rd_ptr    <= r_rd_ptr + PW'(w_tx_rd);
                r_cmt_ptr   <= w_cmt_acc;
                r_wr_ptr    <= w_rewind ? w_cmt_acc : w_wr_acc;
                if (w_oversize) r_err <= 1'b1;
                // Discard mode only lives in RUN; a port reset abandons it.
                if (w_rst_req)
                    r_discard <= 1'b0;
                else if (w_oversize)
                    r_discard <= 1'b1;
                else if (w_tx_acc && r_discard && tx_s_tlast[p])
                    r_discard <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_beat;
        end

        assign tx_s_tready[p]                              = w_tx_rdy;
        assign tx_m_tvalid[p]                              = w_tx_vld;
        assign tx_m_tdata[p*TDATA_WIDTH +: TDATA_WIDTH]    = w_rd_beat[TDATA_WIDTH-1:0];
        assign tx_m_tkeep[p*KW +: KW]                      = w_rd_beat[TDATA_WIDTH +: KW];
        assign tx_m_tuser[p*TUSER_WIDTH +: TUSER_WIDTH]    = w_rd_beat[TDATA_WIDTH+KW +: TUSER_WIDTH];
        assign tx_m_tlast[p]                               = w_rd_beat[BW-1];
        assign rx_m_tvalid[p]                              = w_run && rx_s_tvalid[p];
        assign rx_s_tready[p]                              = w_rx_rdy;
        assign port_quiesced[p]                            = (r_state == c_ST_HOLD);
        assign err_oversize[p]                             = r_err;

`ifdef PG_GUARD_STATS_EN
        logic [15:0]   r_tx_drop, r_rx_drop;
        logic [PW-1:0] w_rw_cnt;
        logic [16:0]   w_tx_sum;

        // Rewound beats of an abandoned partial packet plus oversize-tail beats.
        assign w_rw_cnt = w_rewind ? (w_wr_acc - w_cmt_acc) : '0;
        assign w_tx_sum = {1'b0, r_tx_drop} + 17'(w_rw_cnt) + 17'(w_tx_acc && r_discard);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_tx_drop <= '0;
                r_rx_drop <= '0;
            end else begin
                r_tx_drop <= w_tx_sum[16] ? 16'hFFFF : w_tx_sum[15:0];
                if (!w_run && rx_s_tvalid[p] && (r_rx_drop != 16'hFFFF))
                    r_rx_drop <= r_rx_drop + 16'd1;
            end
        end

        assign stat_tx_drop[p*16 +: 16] = r_tx_drop;
        assign stat_rx_drop[p*16 +: 16] = r_rx_drop;
`else
        assign stat_tx_drop[p*16 +: 16] = 16'h0000;
        assign stat_rx_drop[p*16 +: 16] = 16'h0000;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_pg_port_reset_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pg_port_reset_guard
// Purpose  : Self-checking bench for pg_port_reset_guard. A queue-based
//            reference model (committed packets / open packet per port) tracks
//            the expected behaviour; directed scenarios are followed by
//            randomized traffic and port resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pg_port_reset_guard;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int UW    = 10;
    localparam int DEPTH = 8;

    localparam int c_RUN   = 0;
    localparam int c_FLUSH = 1;
    localparam int c_HOLD  = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]    port_rst;
    logic [NP-1:0]    tx_s_tvalid, tx_s_tready, tx_s_tlast;
    logic [NP*DW-1:0] tx_s_tdata;
    logic [NP*KW-1:0] tx_s_tkeep;
    logic [NP*UW-1:0] tx_s_tuser;
    logic [NP-1:0]    tx_m_tvalid, tx_m_tready, tx_m_tlast;
    logic [NP*DW-1:0] tx_m_tdata;
    logic [NP*KW-1:0] tx_m_tkeep;
    logic [NP*UW-1:0] tx_m_tuser;
    logic [NP-1:0]    rx_s_tvalid, rx_s_tready, rx_s_tlast;
    logic [NP*DW-1:0] rx_s_tdata;
    logic [NP*KW-1:0] rx_s_tkeep;
    logic [NP*UW-1:0] rx_s_tuser;
    logic [NP-1:0]    rx_m_tvalid, rx_m_tready, rx_m_tlast;
    logic [NP*DW-1:0] rx_m_tdata;
    logic [NP*KW-1:0] rx_m_tkeep;
    logic [NP*UW-1:0] rx_m_tuser;
    logic [NP-1:0]    port_quiesced, err_oversize;
    logic [NP*16-1:0] stat_tx_drop, stat_rx_drop;

    always #5 clk = ~clk;

    pg_port_reset_guard #(
        .NUM_PORTS(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst), .port_rst(port_rst),
        .tx_s_tvalid(tx_s_tvalid), .tx_s_tready(tx_s_tready), .tx_s_tlast(tx_s_tlast),
        .tx_s_tdata(tx_s_tdata), .tx_s_tkeep(tx_s_tkeep), .tx_s_tuser(tx_s_tuser),
        .tx_m_tvalid(tx_m_tvalid), .tx_m_tready(tx_m_tready), .tx_m_tlast(tx_m_tlast),
        .tx_m_tdata(tx_m_tdata), .tx_m_tkeep(tx_m_tkeep), .tx_m_tuser(tx_m_tuser),
        .rx_s_tvalid(rx_s_tvalid), .rx_s_tready(rx_s_tready), .rx_s_tlast(rx_s_tlast),
        .rx_s_tdata(rx_s_tdata), .rx_s_tkeep(rx_s_tkeep), .rx_s_tuser(rx_s_tuser),
        .rx_m_tvalid(rx_m_tvalid), .rx_m_tready(rx_m_tready), .rx_m_tlast(rx_m_tlast),
        .rx_m_tdata(rx_m_tdata), .rx_m_tkeep(rx_m_tkeep), .rx_m_tuser(rx_m_tuser),
        .port_quiesced(port_quiesced), .err_oversize(err_oversize),
        .stat_tx_drop(stat_tx_drop), .stat_rx_drop(stat_rx_drop)
    );

    // ---------------- reference model state ----------------
    beat_t cq[NP][$];          // committed, not yet emitted packets (beats)
    beat_t oq[NP][$];          // currently open (uncommitted) packet
    int    mode[NP];
    bit    disc[NP];
    bit    err[NP];
    bit    rxin[NP];
    int    txdrop[NP];
    int    rxdrop[NP];
    bit    m_tx_acc[NP];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            cq[p].delete();
            oq[p].delete();
            mode[p]   = c_HOLD;
            disc[p]   = 1'b0;
            err[p]    = 1'b0;
            rxin[p]   = 1'b0;
            txdrop[p] = 0;
            rxdrop[p] = 0;
        end
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model.
    task automatic step();
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            int    occ;
            bit    e_trdy, e_mv, e_rrdy, e_rmv, cq_empty0, full0, rx_acc, rxin_nxt;
            beat_t hb, nb;
            occ    = cq[p].size() + oq[p].size();
            e_trdy = (mode[p] == c_RUN) && (disc[p] || occ < DEPTH);
            e_mv   = (cq[p].size() != 0);
            e_rrdy = (mode[p] == c_RUN) ? rx_m_tready[p] : 1'b1;
            e_rmv  = (mode[p] == c_RUN) && rx_s_tvalid[p];

            check_value($sformatf("tx_s_tready[%0d]", p), tx_s_tready[p], e_trdy);
            check_value($sformatf("tx_m_tvalid[%0d]", p), tx_m_tvalid[p], e_mv);
            check_value($sformatf("rx_s_tready[%0d]", p), rx_s_tready[p], e_rrdy);
            check_value($sformatf("rx_m_tvalid[%0d]", p), rx_m_tvalid[p], e_rmv);
            check_value($sformatf("port_quiesced[%0d]", p), port_quiesced[p], mode[p] == c_HOLD);
            check_value($sformatf("err_oversize[%0d]", p), err_oversize[p], err[p]);
`ifdef PG_GUARD_STATS_EN
            check_value($sformatf("stat_tx_drop[%0d]", p), stat_tx_drop[p*16 +: 16], sat16(txdrop[p]));
            check_value($sformatf("stat_rx_drop[%0d]", p), stat_rx_drop[p*16 +: 16], sat16(rxdrop[p]));
`else
            check_value($sformatf("stat_tx_drop[%0d]", p), stat_tx_drop[p*16 +: 16], 0);
            check_value($sformatf("stat_rx_drop[%0d]", p), stat_rx_drop[p*16 +: 16], 0);
`endif
            if (e_mv) begin
                hb = cq[p][0];
                check_value($sformatf("tx_m_tdata[%0d]", p), tx_m_tdata[p*DW +: DW], hb.d);
                check_value($sformatf("tx_m_tkeep[%0d]", p), tx_m_tkeep[p*KW +: KW], hb.k);
                check_value($sformatf("tx_m_tuser[%0d]", p), tx_m_tuser[p*UW +: UW], hb.u);
                check_value($sformatf("tx_m_tlast[%0d]", p), tx_m_tlast[p], hb.l);
            end
            if (e_rmv) begin
                check_value($sformatf("rx_m_tdata[%0d]", p), rx_m_tdata[p*DW +: DW], rx_s_tdata[p*DW +: DW]);
                check_value($sformatf("rx_m_tlast[%0d]", p), rx_m_tlast[p], rx_s_tlast[p]);
            end

            m_tx_acc[p] = tx_s_tvalid[p] && e_trdy;
            if (rst) continue;

            cq_empty0 = (cq[p].size() == 0);
            full0     = (occ == DEPTH);
            if (e_mv && tx_m_tready[p]) void'(cq[p].pop_front());
            if (m_tx_acc[p]) begin
                nb.d = tx_s_tdata[p*DW +: DW];
                nb.k = tx_s_tkeep[p*KW +: KW];
                nb.u = tx_s_tuser[p*UW +: UW];
                nb.l = tx_s_tlast[p];
                if (disc[p]) begin
                    txdrop[p]++;
                    if (nb.l) disc[p] = 1'b0;
                end else begin
                    oq[p].push_back(nb);
                    if (nb.l) while (oq[p].size() > 0) cq[p].push_back(oq[p].pop_front());
                end
            end
            if (full0 && cq_empty0) begin      // whole FIFO taken by one open packet
                err[p]    = 1'b1;
                txdrop[p] += oq[p].size();
                oq[p].delete();
                disc[p]   = 1'b1;
            end
            rx_acc   = rx_s_tvalid[p] && e_rrdy;
            rxin_nxt = rx_acc ? !rx_s_tlast[p] : rxin[p];
            if (mode[p] != c_RUN && rx_s_tvalid[p]) rxdrop[p]++;
            case (mode[p])
                c_RUN: if (port_rst[p]) begin
                    txdrop[p] += oq[p].size();
                    oq[p].delete();
                    disc[p] = 1'b0;
                    mode[p] = c_FLUSH;
                end
                c_FLUSH: if (cq_empty0) mode[p] = c_HOLD;
                default: if (!port_rst[p] && !rxin_nxt) mode[p] = c_RUN;
            endcase
            rxin[p] = rxin_nxt;
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload(input int p);
        tx_s_tdata[p*DW +: DW] = $urandom();
        tx_s_tkeep[p*KW +: KW] = KW'($urandom());
        tx_s_tuser[p*UW +: UW] = UW'($urandom());
        rx_s_tdata[p*DW +: DW] = $urandom();
        rx_s_tkeep[p*KW +: KW] = KW'($urandom());
        rx_s_tuser[p*UW +: UW] = UW'($urandom());
    endtask

    // Present one TX beat on port p and hold it until the model accepts it.
    task automatic send_beat(input int p, input bit last);
        int n;
        tx_s_tvalid[p] = 1'b1;
        tx_s_tlast[p]  = last;
        rand_payload(p);
        n = 0;
        do begin
            step();
            n++;
        end while (!m_tx_acc[p] && n < 40);
        if (!m_tx_acc[p]) check_value($sformatf("send_timeout[%0d]", p), 0, 1);
        tx_s_tvalid[p] = 1'b0;
        tx_s_tlast[p]  = 1'b0;
    endtask

    task automatic rand_cycle(input int tv, input int tl, input int mr, input int rv,
                              input int rl, input int ar, input logic [NP-1:0] prst_mask,
                              input int prst_pct);
        for (int p = 0; p < NP; p++) begin
            tx_s_tvalid[p] = ($urandom_range(99) < tv);
            tx_s_tlast[p]  = ($urandom_range(99) < tl);
            tx_m_tready[p] = ($urandom_range(99) < mr);
            rx_s_tvalid[p] = ($urandom_range(99) < rv);
            rx_s_tlast[p]  = ($urandom_range(99) < rl);
            rx_m_tready[p] = ($urandom_range(99) < ar);
            rand_payload(p);
            if (!prst_mask[p])                        port_rst[p] = 1'b0;
            else if ($urandom_range(99) < prst_pct)   port_rst[p] = ~port_rst[p];
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        port_rst = '0;
        tx_s_tvalid = '0; tx_s_tlast = '0; tx_s_tdata = '0; tx_s_tkeep = '0; tx_s_tuser = '0;
        tx_m_tready = '1;
        rx_s_tvalid = '1; rx_s_tlast = '0; rx_s_tdata = '0; rx_s_tkeep = '0; rx_s_tuser = '0;
        rx_m_tready = '1;
        model_reset();
        repeat (3) step();                         // reset values
        rst = 1'b0;
        rx_s_tvalid = '0;
        repeat (3) step();

        // Port 0: 3-beat packet, emitted only after its tlast
        send_beat(0, 1'b0); send_beat(0, 1'b0); send_beat(0, 1'b1);
        repeat (5) step();

        // Port 1: committed 2-beat packet, then reset after 2 of 4 beats
        tx_m_tready[1] = 1'b0;
        send_beat(1, 1'b0); send_beat(1, 1'b1);
        send_beat(1, 1'b0); send_beat(1, 1'b0);
        port_rst[1] = 1'b1;
        tx_m_tready[1] = 1'b1;
        repeat (8) step();
        port_rst[1] = 1'b0;
        repeat (3) step();

        // Port 2: RX sunk while held in reset, then released mid-packet
        rx_s_tvalid[2] = 1'b1;
        port_rst[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rx_s_tlast[2] = ($urandom_range(3) == 0);
            rand_payload(2);
            step();
        end
        rx_s_tlast[2] = 1'b0;
        repeat (2) step();
        port_rst[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_s_tlast[2] = (i == 3);
            rand_payload(2);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            rx_s_tlast[2] = (i == 2);
            rand_payload(2);
            step();
        end
        rx_s_tvalid[2] = 1'b0;
        rx_s_tlast[2]  = 1'b0;
        step();

        // Port 3: 10-beat oversize packet, then a normal 2-beat packet
        for (int i = 0; i < 10; i++) send_beat(3, i == 9);
        send_beat(3, 1'b0); send_beat(3, 1'b1);
        repeat (6) step();

        // Random traffic everywhere, port resets on port 3 only
        for (int i = 0; i < 2500; i++) rand_cycle(70, 25, 75, 60, 30, 80, 4'b1000, 3);

        // Random traffic and resets on all ports, long packets, mid-run block reset
        for (int i = 0; i < 3000; i++) begin
            rst = (i >= 1500 && i < 1502);
            rand_cycle(85, 10, 60, 70, 20, 60, 4'b1111, 4);
        end
        rst = 1'b0;
        port_rst = '0;
        tx_s_tvalid = '0;
        rx_s_tvalid = '0;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
